// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of clocks needed to walk the full operand width.
    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Legal geometry: 1 <= digit <= width and width divisible by digit.
    function automatic bit digit_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder cell; the ripple chain is built from these.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first,
// carry held in a register between digits, valid/ready on both sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int CNT_W = $clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_geometry
            $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic [WIDTH-1:0] sum_sh_next;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [DIGIT:0]   chain_c;
    logic [DIGIT-1:0] chain_s;
    logic             accept;
    logic             last_step;

    assign accept    = (state_reg == IDLE) && in_valid;
    assign last_step = (state_reg == RUN) && (cnt_reg == LAST_STEP);

    // Ripple chain over the low digit of the operand shift registers.
    assign chain_c[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
            fa_bit u_fa (
                .a  (a_sh_reg[gi]),
                .b  (b_sh_reg[gi]),
                .ci (chain_c[gi]),
                .s  (chain_s[gi]),
                .co (chain_c[gi+1])
            );
        end
    endgenerate

    // New sum digit enters at the MSB end so the last digit lands LSB-aligned.
    assign sum_sh_next = (sum_sh_reg >> DIGIT) | (WIDTH'(chain_s) << (WIDTH - DIGIT));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, digit shifting and result latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1; the borrow-in inverts the injected carry.
            a_sh_reg  <= a;
            b_sh_reg  <= sub ? ~b : b;
            carry_reg <= cin ^ sub;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_sh_reg   <= a_sh_reg >> DIGIT;
            b_sh_reg   <= b_sh_reg >> DIGIT;
            sum_sh_reg <= sum_sh_next;
            carry_reg  <= chain_c[DIGIT];
            cnt_reg    <= cnt_reg + CNT_W'(1);
            if (last_step) begin
                // Top cell of the final digit is bit WIDTH-1.
                sum_reg  <= sum_sh_next;
                cout_reg <= chain_c[DIGIT];
                ovf_reg  <= chain_c[DIGIT] ^ chain_c[DIGIT-1];
            end
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit/1-digit instance driven with
// directed vectors and a 16-bit/4-digit instance driven with random traffic.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    logic rst = 1'b1;

    logic       iv8 = 1'b0, ir8, ci8 = 1'b0, sb8 = 1'b0, ov8, or8 = 1'b1, co8, of8;
    logic [7:0] a8 = '0, b8 = '0, s8;

    logic        iv16 = 1'b0, ir16, ci16 = 1'b0, sb16 = 1'b0, ov16, or16 = 1'b1, co16, of16;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        rnd16 = 1'b0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .ovf(of8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(ci16), .sub(sb16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .cout(co16), .ovf(of16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent reference: whole-word arithmetic, overflow from operand signs.
    function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b,
                                     input logic c, input logic s);
        logic [15:0] bb;
        logic [16:0] full;
        exp_t        e;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + 17'(c ^ s);
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        e.acc  = 0;
        return e;
    endfunction

    // Monitor for the 8-bit instance.
    logic       pv8 = 1'b0, pc8 = 1'b0, po8 = 1'b0;
    logic [7:0] ps8 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv8 = 1'b0;
        end else begin
            if (ov8 && !pv8) begin
                if (q8.size() == 0) chk("spurious_valid8", 1, 0);
                else                chk("latency8", cyc - q8[0].acc, 8);
            end
            if (ov8 && pv8) begin
                chk("hold_sum8", s8, ps8);
                chk("hold_cout8", co8, pc8);
                chk("hold_ovf8", of8, po8);
                chk("hold_in_ready8", ir8, 0);
            end
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    chk("extra_result8", 1, 0);
                end else begin
                    e = q8.pop_front();
                    $display("dut8  result sum=%02h cout=%0d ovf=%0d", s8, co8, of8);
                    chk("sum8", s8, e.sum);
                    chk("cout8", co8, e.cout);
                    chk("ovf8", of8, e.ovf);
                end
            end
            pv8 = ov8; ps8 = s8; pc8 = co8; po8 = of8;
        end
    end

    // Monitor for the 16-bit instance.
    logic        pv16 = 1'b0, pc16 = 1'b0, po16 = 1'b0;
    logic [15:0] ps16 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv16 = 1'b0;
        end else begin
            if (ov16 && !pv16) begin
                if (q16.size() == 0) chk("spurious_valid16", 1, 0);
                else                 chk("latency16", cyc - q16[0].acc, 4);
            end
            if (ov16 && pv16) begin
                chk("hold_sum16", s16, ps16);
                chk("hold_cout16", co16, pc16);
                chk("hold_ovf16", of16, po16);
            end
            if (ov16 && or16) begin
                if (q16.size() == 0) begin
                    chk("extra_result16", 1, 0);
                end else begin
                    e = q16.pop_front();
                    $display("dut16 result sum=%04h cout=%0d ovf=%0d", s16, co16, of16);
                    chk("sum16", s16, e.sum);
                    chk("cout16", co16, e.cout);
                    chk("ovf16", of16, e.ovf);
                end
            end
            pv16 = ov16; ps16 = s16; pc16 = co16; po16 = of16;
        end
    end

    // Random consumer backpressure for the 16-bit instance.
    always @(posedge clk) begin
        if (rnd16) begin
            #1;
            or16 = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s, input logic [7:0] es, input logic ec,
                         input logic eo);
        int   n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        a8 = a; b8 = b; ci8 = c; sb8 = s; iv8 = 1'b1;
        @(negedge clk);
        while (!ir8 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!ir8) begin
            chk("accept8_timeout", 0, 1);
        end else begin
            e.sum = 16'(es); e.cout = ec; e.ovf = eo; e.acc = cyc + 1;
            q8.push_back(e);
            $display("dut8  issue a=%02h b=%02h cin=%0d sub=%0d", a, b, c, s);
        end
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; ci8 = 1'b1; sb8 = 1'b1;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic s);
        int   n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        a16 = a; b16 = b; ci16 = c; sb16 = s; iv16 = 1'b1;
        @(negedge clk);
        while (!ir16 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ir16) begin
            chk("accept16_timeout", 0, 1);
        end else begin
            e = model16(a, b, c, s);
            e.acc = cyc + 1;
            q16.push_back(e);
            $display("dut16 issue a=%04h b=%04h cin=%0d sub=%0d", a, b, c, s);
        end
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        ci16 = 1'($urandom); sb16 = 1'($urandom);
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (q8.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (q8.size() != 0) begin
            chk("drain8_timeout", q8.size(), 0);
            q8.delete();
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        // Reset behaviour.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_during_rst8", ir8, 0);
        chk("in_ready_during_rst16", ir16, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready8", ir8, 1);
        chk("reset_out_valid8", ov8, 0);
        chk("reset_sum8", s8, 0);
        chk("reset_cout8", co8, 0);
        chk("reset_ovf8", of8, 0);
        chk("reset_in_ready16", ir16, 1);

        // Directed vectors on the 8-bit, 1-digit instance.
        send8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); drain8();
        send8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0); drain8();
        send8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1); drain8();
        send8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1); drain8();
        send8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0); drain8();
        send8(8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0); drain8();

        // Backpressure: result must hold while the consumer stalls.
        or8 = 1'b0;
        send8(8'h3C, 8'h44, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
        n = 0;
        while (!ov8 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("bp_out_valid8", ov8, 1);
        repeat (5) @(negedge clk);
        chk("bp_still_valid8", ov8, 1);
        @(posedge clk); #1;
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_out_valid8", ov8, 0);
        chk("bp_release_in_ready8", ir8, 1);
        drain8();

        // Abort by reset mid-run.
        send8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        q8.delete();
        @(negedge clk);
        chk("abort_in_ready_in_rst8", ir8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid8", ov8, 0);
        chk("abort_sum8", s8, 0);
        chk("abort_cout8", co8, 0);
        chk("abort_ovf8", of8, 0);
        chk("abort_in_ready8", ir8, 1);
        repeat (12) @(negedge clk);
        chk("abort_no_valid8", ov8, 0);
        send8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0); drain8();

        // Random traffic on the 16-bit, 4-digit instance.
        rnd16 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        n = 0;
        while (q16.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("queue16_empty", q16.size(), 0);
        rnd16 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
